// File: rtl/mul_chain_sched.sv
// mul_chain_sched: request/response scheduler that evaluates y = a (fast path,
// sel=0) or y = low32(a*b*c*3) (slow path, sel=1). The slow path reuses one
// 32x32 multiplier over three steps. Each step holds the multiplier operands
// stable for MC_CYCLES clocks, so the multiplier can be timed as a multicycle
// path.
//
// Ports:
//   clk       - single clock, all state updates on the rising edge
//   reset_n   - synchronous active-low reset
//   in_valid  - request valid (a, b, c, sel are captured on accept)
//   in_ready  - block is idle and can accept a request
//   a, b, c   - 16-bit operands
//   sel       - 0 = fast pass-through of a, 1 = triple-multiply path
//   out_valid - result valid, held until out_ready
//   out_ready - consumer accepts the result
//   y         - 32-bit result (retained after the handshake)
//   busy      - high in any state other than IDLE
module mul_chain_sched #(
    parameter int MC_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic [15:0] c,
    input  logic        sel,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] y,
    output logic        busy
);

    generate
        if (MC_CYCLES < 1 || MC_CYCLES > 8) begin : g_bad_mc_cycles
            $error("mul_chain_sched: MC_CYCLES must be in 1..8");
        end
    endgenerate

    localparam logic [2:0] CNT_LAST = 3'(MC_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        STEP1,
        STEP2,
        STEP3,
        DONE
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [2:0]  cnt;
    logic [31:0] acc;
    logic [31:0] op_y;
    logic [15:0] c_r;
    logic [31:0] prod;
    logic [31:0] y_r;
    logic        accept;
    logic        step_last;

    // acc doubles as the left multiplier operand: it is only written on the
    // last cycle of a step, which is exactly the entry edge of the next step,
    // so both multiplier inputs stay stable for the whole step.
    assign prod      = acc * op_y;
    assign step_last = (cnt == CNT_LAST);
    assign y         = y_r;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                in_ready = reset_n;
                if (in_valid && reset_n) begin
                    accept    = 1'b1;
                    state_nxt = sel ? STEP1 : DONE;
                end
            end
            STEP1: if (step_last) state_nxt = STEP2;
            STEP2: if (step_last) state_nxt = STEP3;
            STEP3: if (step_last) state_nxt = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt  <= '0;
            acc  <= '0;
            op_y <= '0;
            c_r  <= '0;
            y_r  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        cnt  <= '0;
                        acc  <= {16'd0, a};
                        op_y <= {16'd0, b};
                        c_r  <= c;
                        if (!sel) y_r <= {16'd0, a};
                    end
                end
                STEP1, STEP2, STEP3: begin
                    if (step_last) begin
                        cnt <= '0;
                        acc <= prod;
                        if (state == STEP1) op_y <= {16'd0, c_r};
                        if (state == STEP2) op_y <= 32'd3;
                        if (state == STEP3) y_r  <= prod;
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_chain_sched.sv
// Self-checking bench for mul_chain_sched: a table of directed vectors on an
// MC_CYCLES=2 instance, hand-written sequences for back-pressure and reset
// abort, and back-to-back streaming on MC_CYCLES=1 and MC_CYCLES=8 instances.
module tb_mul_chain_sched;

    localparam int MC = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a, b, c;
    logic        sel;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] y;
    logic        busy;

    // streaming instances (index 0: MC_CYCLES=1, index 1: MC_CYCLES=8)
    logic        rst_m;
    logic        one = 1'b1;
    logic        rdy_m [2];
    logic        ov_m  [2];
    logic        busy_m[2];
    logic [31:0] y_m   [2];
    logic [15:0] a_m   [2];
    logic [15:0] b_m   [2];
    logic [15:0] c_m   [2];
    int          idx_m [2];
    logic [15:0] ma [4];
    logic [15:0] mb [4];
    logic [15:0] mc [4];

    int chk  = 0;
    int errs = 0;
    int cyc  = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mul_chain_sched #(.MC_CYCLES(MC)) u_dut (
        .clk(clk), .reset_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c(c), .sel(sel), .out_valid(out_valid),
        .out_ready(out_ready), .y(y), .busy(busy)
    );

    mul_chain_sched #(.MC_CYCLES(1)) u_mc1 (
        .clk(clk), .reset_n(rst_m), .in_valid(one), .in_ready(rdy_m[0]),
        .a(a_m[0]), .b(b_m[0]), .c(c_m[0]), .sel(one), .out_valid(ov_m[0]),
        .out_ready(one), .y(y_m[0]), .busy(busy_m[0])
    );

    mul_chain_sched #(.MC_CYCLES(8)) u_mc8 (
        .clk(clk), .reset_n(rst_m), .in_valid(one), .in_ready(rdy_m[1]),
        .a(a_m[1]), .b(b_m[1]), .c(c_m[1]), .sel(one), .out_valid(ov_m[1]),
        .out_ready(one), .y(y_m[1]), .busy(busy_m[1])
    );

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            a_m[k] = ma[idx_m[k]];
            b_m[k] = mb[idx_m[k]];
            c_m[k] = mc[idx_m[k]];
        end
    end

    typedef struct {
        logic        sel;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] c;
        logic [31:0] exp_y;
        int          exp_lat;   // clock edges from the accept edge to DONE entry
    } vec_t;

    vec_t vt[8];

    function automatic logic [31:0] ref_y(input logic [15:0] ra, input logic [15:0] rb,
                                          input logic [15:0] rc);
        logic [31:0] p;
        p = {16'd0, ra} * {16'd0, rb};
        p = p * {16'd0, rc};
        p = p * 32'd3;
        return p;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Presents a request for one edge, then scrambles the operand inputs so
    // that any late sampling of a/b/c/sel would corrupt the result.
    task automatic issue(input logic s, input logic [15:0] ia, input logic [15:0] ib,
                         input logic [15:0] ic);
        check("ready_before_accept", 32'(in_ready), 32'd1);
        sel      = s;
        a        = ia;
        b        = ib;
        c        = ic;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        sel      = ~s;
        a        = ~ia;
        b        = ib ^ 16'h5A5A;
        c        = ic + 16'd17;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 100) begin
            tick();
            lat++;
        end
        if (!out_valid) check("done_timeout", 32'(out_valid), 32'd1);
    endtask

    task automatic run_multi(input int k, input int mcy);
        int          acc_cyc[3];
        logic [31:0] expq[3];
        int          got   = 0;
        int          nacc  = 0;
        int          guard = 0;
        while (got < 3 && guard < 500) begin
            @(negedge clk);
            guard++;
            if (ov_m[k]) begin
                check($sformatf("stream_y_mc%0d_%0d", mcy, got), y_m[k], expq[got]);
                got++;
            end
            if (rdy_m[k] && nacc < 3) begin
                acc_cyc[nacc] = cyc;
                expq[nacc]    = ref_y(ma[idx_m[k]], mb[idx_m[k]], mc[idx_m[k]]);
                nacc++;
                @(posedge clk);
                #1;
                idx_m[k] = idx_m[k] + 1;
            end
        end
        check($sformatf("stream_results_mc%0d", mcy), 32'(got), 32'd3);
        if (nacc == 3) begin
            check($sformatf("stream_space01_mc%0d", mcy), 32'(acc_cyc[1] - acc_cyc[0]),
                  32'(3 * mcy + 2));
            check($sformatf("stream_space12_mc%0d", mcy), 32'(acc_cyc[2] - acc_cyc[1]),
                  32'(3 * mcy + 2));
        end
    endtask

    initial begin
        int   lat;
        logic seen;

        // sel=0 results appear in the cycle right after the accept edge
        vt[0] = '{1'b1, 16'd3,     16'd5,     16'd7,     32'h0000_013B, 3 * MC};
        vt[1] = '{1'b0, 16'h1234,  16'hFFFF,  16'hFFFF,  32'h0000_1234, 0};
        vt[2] = '{1'b1, 16'hFFFF,  16'hFFFF,  16'hFFFF,  32'h0008_FFFD, 3 * MC};
        vt[3] = '{1'b1, 16'd2,     16'd3,     16'd4,     32'h0000_0048, 3 * MC};
        vt[4] = '{1'b0, 16'hABCD,  16'd1,     16'd2,     32'h0000_ABCD, 0};
        vt[5] = '{1'b1, 16'h0100,  16'h0100,  16'h0100,  32'h0300_0000, 3 * MC};
        vt[6] = '{1'b1, 16'd0,     16'h0055,  16'h0066,  32'h0000_0000, 3 * MC};
        vt[7] = '{1'b1, 16'd1,     16'd1,     16'd1,     32'h0000_0003, 3 * MC};

        ma = '{16'd3, 16'hFFFF, 16'h1234, 16'd1};
        mb = '{16'd5, 16'hFFFF, 16'h0010, 16'd1};
        mc = '{16'd7, 16'hFFFF, 16'h0020, 16'd1};
        idx_m[0] = 0;
        idx_m[1] = 0;

        rst_n     = 1'b0;
        rst_m     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a = '0; b = '0; c = '0; sel = 1'b0;

        // reset state
        tick();
        tick();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_y", y, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // table-driven vectors
        for (int i = 0; i < 8; i++) begin
            issue(vt[i].sel, vt[i].a, vt[i].b, vt[i].c);
            wait_done(lat);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vt[i].exp_lat));
            check($sformatf("vec%0d_y", i), y, vt[i].exp_y);
            check($sformatf("vec%0d_busy", i), 32'(busy), 32'd1);
            if (i % 2 == 1) begin
                tick();
                tick();
                check($sformatf("vec%0d_y_hold", i), y, vt[i].exp_y);
            end
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            check($sformatf("vec%0d_ov_clear", i), 32'(out_valid), 32'd0);
            check($sformatf("vec%0d_idle_ready", i), 32'(in_ready), 32'd1);
            check($sformatf("vec%0d_y_retained", i), y, vt[i].exp_y);
        end

        // back-pressure: new request held while a result is pending
        issue(1'b1, 16'd3, 16'd5, 16'd7);
        wait_done(lat);
        in_valid = 1'b1;
        sel = 1'b0; a = 16'h1111; b = 16'h2222; c = 16'h3333;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("bp%0d_y", i), y, 32'h0000_013B);
            check($sformatf("bp%0d_out_valid", i), 32'(out_valid), 32'd1);
            check($sformatf("bp%0d_in_ready", i), 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_release_ov", 32'(out_valid), 32'd0);
        check("bp_release_ready", 32'(in_ready), 32'd1);
        check("bp_release_y", y, 32'h0000_013B);
        tick();
        in_valid = 1'b0;
        check("bp_new_ov", 32'(out_valid), 32'd1);
        check("bp_new_y", y, 32'h0000_1111);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // reset during STEP2 aborts the request
        issue(1'b1, 16'h0010, 16'h0020, 16'h0030);
        for (int i = 0; i < MC; i++) tick();
        check("abort_in_step", 32'(busy), 32'd1);
        rst_n = 1'b0;
        tick();
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_y", y, 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b1;
        #1;
        check("abort_release_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (out_valid || busy) seen = 1'b1;
        end
        out_ready = 1'b0;
        check("abort_no_stale_result", 32'(seen), 32'd0);

        // back-to-back streaming on MC_CYCLES=1 and MC_CYCLES=8
        tick();
        rst_m = 1'b1;
        fork
            run_multi(0, 1);
            run_multi(1, 8);
        join

        $display("Simulation finished: %0d checks, %0d errors", chk, errs);
        $finish;
    end

endmodule

// File: doc/mul_chain_sched.md
MUL_CHAIN_SCHED -- requirements
Module: mul_chain_sched

Interface
REQ-001 Parameter MC_CYCLES, default 2: clock cycles each multiply step holds its operands stable (multicycle budget); legal range 1..8, any other value SHALL fail elaboration.
REQ-002 Port clk  input  1  single clock; all state updates on posedge clk.
REQ-003 Port reset_n  input  1  reset, synchronous, active-low.
REQ-004 Port in_valid  input  1  request valid.
REQ-005 Port in_ready  output  1  block can accept a request.
REQ-006 Port a  input  16  operand A.
REQ-007 Port b  input  16  operand B.
REQ-008 Port c  input  16  operand C.
REQ-009 Port sel  input  1  0 = fast path, 1 = slow triple-multiply path.
REQ-010 Port out_valid  output  1  result valid.
REQ-011 Port out_ready  input  1  consumer accepts result.
REQ-012 Port y  output  32  result.
REQ-013 Port busy  output  1  high in any state other than IDLE.

Function
REQ-014 States SHALL be IDLE, STEP1, STEP2, STEP3, DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-015 Accept = in_valid && in_ready; on accept, a, b, c, sel are captured into registers; inputs are ignored at all other times.
REQ-016 Accept with sel=0: next state DONE, y = {16'd0, a}; out_valid visible 1 cycle after the accept edge.
REQ-017 Accept with sel=1: next state STEP1, step counter = 0.
REQ-018 One shared multiplier SHALL be used (32x32, low 32 bits kept), fed only from operand registers that change solely at step entry, never mid-step.
REQ-019 Each STEPn lasts exactly MC_CYCLES cycles; the counter runs 0..MC_CYCLES-1, and the product is captured into acc only on the last cycle of the step, which is also when the state advances.
REQ-020 STEP1: acc = a*b (full 32-bit product); STEP2: acc = low32(acc*c); STEP3: acc = low32(acc*3); STEP3 exit loads y = acc result and enters DONE.
REQ-021 sel=1 latency: out_valid visible exactly 3*MC_CYCLES cycles after the accept edge.
REQ-022 DONE: y and out_valid held stable until out_valid && out_ready; that handshake moves to IDLE and clears out_valid; y retains its value.
REQ-023 No overlap: a new request is accepted only in IDLE, so minimum accept-to-accept spacing is 3*MC_CYCLES+2 cycles (sel=1) or 3 cycles (sel=0).
REQ-024 in_valid asserted while busy: no capture, no state change; the requester holds its request.
REQ-025 Operand changes on a, b, c, sel after accept SHALL NOT affect the in-flight result.
REQ-026 Arithmetic overflow wraps modulo 2^32 and raises no flag.

Reset
REQ-027 While reset_n is low at a clock edge: state = IDLE, counter = 0, acc = 0, y = 0, out_valid = 0, busy = 0, in_ready = 0.
REQ-028 First cycle after reset_n rises: in_ready = 1.
REQ-029 Reset in any STEP or DONE state aborts the operation; no out_valid for the aborted request is ever produced.

Verification
REQ-030 MC_CYCLES=2, sel=1, a=3, b=5, c=7 -> out_valid high 6 cycles after accept, y=0x0000013B (315).
REQ-031 sel=0, a=0x1234, b=c=0xFFFF -> out_valid 1 cycle after accept, y=0x00001234.
REQ-032 sel=1, a=b=c=0xFFFF -> y=0x0008FFFD (wraparound check), latency 3*MC_CYCLES.
REQ-033 Result pending, out_ready low 4 cycles, new in_valid with different operands -> y and out_valid unchanged, in_ready=0, no capture; out_ready high -> IDLE next cycle, then new request accepted.
REQ-034 Reset pulsed during STEP2 -> out_valid=0, y=0 next cycle; in_ready=1 after release; no stale result appears.
REQ-035 MC_CYCLES=1 and MC_CYCLES=8, in_valid and out_ready tied high, 3 back-to-back sel=1 requests -> accepts spaced 5 and 26 cycles apart, each y matches the reference model.
